// File: rtl/qk_inst_sequencer.sv
// Instruction sequencer for one K*Q + normalization pass on fullchip.
// Streams Q/K beats into qmem/kmem, then replays a fixed load/exec/drain/sfp program.
module qk_inst_sequencer #(
    parameter int unsigned bw          = 8,
    parameter int unsigned pr          = 8,
    parameter int unsigned core        = 2,
    parameter int unsigned col         = 8,
    parameter int unsigned total_cycle = 8,
    parameter int unsigned gap         = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [pr*bw*core-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [pr*bw*core-1:0]   mem_in,
    output logic [19:0]             inst,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [3:0] {
        StIdle, StQwr, StKwr, StLoad, StWait1, StExec,
        StWait2, StDrain, StAcc, StDiv, StWb, StDone
    } state_e;

    localparam logic [4:0] TcLast   = 5'(total_cycle - 1);
    localparam logic [4:0] ColLast  = 5'(col - 1);
    localparam logic [4:0] LoadLast = 5'(col + 1);
    localparam logic [4:0] GapLast  = 5'(gap - 1);
    localparam logic [4:0] WbLast   = 5'(2 * total_cycle - 1);
    localparam logic [4:0] ColCnt   = 5'(col);

    state_e      state_q, state_d, nxt;
    logic [4:0]  cnt_q, cnt_d, limit;
    logic        adv, hs;
    logic [19:0] inst_d;

    assign in_ready = !reset && (state_q == StQwr || state_q == StKwr);
    assign hs       = in_valid && in_ready;

    // Every state advances cnt each cycle until its limit; stream states only on a handshake.
    always_comb begin
        adv   = 1'b1;
        limit = 5'd0;
        nxt   = state_q;
        unique case (state_q)
            StIdle:  begin adv = start; nxt = StQwr; end
            StQwr:   begin adv = hs; limit = TcLast;  nxt = StKwr;   end
            StKwr:   begin adv = hs; limit = ColLast; nxt = StLoad;  end
            StLoad:  begin limit = LoadLast; nxt = StWait1; end
            StWait1: begin limit = GapLast;  nxt = StExec;  end
            StExec:  begin limit = TcLast;   nxt = StWait2; end
            StWait2: begin limit = GapLast;  nxt = StDrain; end
            StDrain: begin limit = TcLast;   nxt = StAcc;   end
            StAcc:   begin limit = TcLast;   nxt = StDiv;   end
            StDiv:   begin nxt = StWb; end
            StWb:    begin limit = WbLast;   nxt = StDone;  end
            StDone:  begin nxt = StIdle; end
            default: begin nxt = StIdle; end
        endcase

        state_d = state_q;
        cnt_d   = cnt_q;
        if (adv) begin
            if (cnt_q == limit) begin
                state_d = nxt;
                cnt_d   = 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // inst is decoded from the upcoming state/cnt so it lines up with the state it encodes.
    always_comb begin
        inst_d = 20'h0;
        unique case (state_d)
            StLoad: begin
                inst_d[6] = 1'b1;
                if (cnt_d != 5'd0 && cnt_d <= ColCnt) begin
                    inst_d[3]     = 1'b1;
                    inst_d[15:12] = cnt_d[3:0] - 4'd1;
                end
            end
            StExec: begin
                inst_d[7]     = 1'b1;
                inst_d[5]     = 1'b1;
                inst_d[15:12] = cnt_d[3:0];
            end
            StDrain: begin
                inst_d[16]   = 1'b1;
                inst_d[0]    = 1'b1;
                inst_d[11:8] = cnt_d[3:0];
            end
            StAcc: begin
                inst_d[17]   = 1'b1;
                inst_d[1]    = 1'b1;
                inst_d[11:8] = cnt_d[3:0];
            end
            StDiv: inst_d[18] = 1'b1;
            StWb: begin
                inst_d[11:8] = cnt_d[4:1];
                if (!cnt_d[0]) begin
                    inst_d[1]  = 1'b1;
                    inst_d[18] = 1'b1;
                end else begin
                    inst_d[0]  = 1'b1;
                    inst_d[19] = 1'b1;
                end
            end
            default: inst_d = 20'h0;
        endcase

        if (hs) begin
            if (state_q == StQwr) inst_d[4] = 1'b1;
            else                  inst_d[2] = 1'b1;
            inst_d[15:12] = cnt_q[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            inst    <= 20'h0;
            mem_in  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst    <= inst_d;
            busy    <= (state_d != StIdle);
            done    <= (state_d == StDone);
            if (hs) mem_in <= in_data;
        end
    end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Self-checking bench for qk_inst_sequencer: a pass-level trace model predicts
// inst/busy/done/in_ready/mem_in for every cycle and a compare process checks them.
module tb_qk_inst_sequencer;

    localparam int unsigned BW = 8, PR = 8, CORE = 2, COL = 8, TC = 8, GAP = 10;
    localparam int unsigned W = PR * BW * CORE;

    localparam logic [19:0] SWR = 20'h80000, SDIV = 20'h40000, SACC = 20'h20000;
    localparam logic [19:0] OFR = 20'h10000, EXE = 20'h00080, LD = 20'h00040;
    localparam logic [19:0] QRD = 20'h00020, QWR = 20'h00010, KRD = 20'h00008;
    localparam logic [19:0] KWR = 20'h00004, PRD = 20'h00002, PWR = 20'h00001;

    typedef struct {
        logic [19:0]  inst;
        logic         busy;
        logic         done;
        logic         rdy;
        logic [W-1:0] mem;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_ready, busy, done;
    logic [W-1:0]  in_data, mem_in;
    logic [19:0]   inst;

    exp_t          exp_q[$];
    logic          sv_valid[$];
    logic [W-1:0]  sv_data[$];
    logic [W-1:0]  model_mem;
    int            n_chk = 0, n_fail = 0, busy_cnt = 0, done_cnt = 0, bubbles = 0;

    qk_inst_sequencer #(
        .bw(BW), .pr(PR), .core(CORE), .col(COL), .total_cycle(TC), .gap(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_in(mem_in), .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] beat_data(input int seed, input int b);
        logic [W-1:0] d;
        for (int i = 0; i < int'(PR * CORE); i++) d[i*BW +: BW] = 8'(seed * 37 + b * 16 + i);
        return d;
    endfunction

    task automatic push(input logic [19:0] i, input logic b, input logic d, input logic r);
        exp_t e;
        e.inst = i; e.busy = b; e.done = d; e.rdy = r; e.mem = model_mem;
        exp_q.push_back(e);
    endtask

    // Pass model: stream phase driven by the valid schedule, then the fixed program.
    task automatic build(input logic [31:0] mask, input int seed);
        logic [19:0] pend = 20'h0;
        logic [19:0] tw[$];
        int beats = 0, j = 0;
        bubbles = 0;
        sv_valid.delete();
        sv_data.delete();
        while (beats < int'(TC + COL)) begin
            logic v;
            push(pend, 1'b1, 1'b0, 1'b1);
            v = !(j < 32 && mask[j]);
            sv_valid.push_back(v);
            sv_data.push_back(beat_data(seed, beats));
            if (v) begin
                if (beats < int'(TC)) pend = QWR | (20'(beats) << 12);
                else                  pend = KWR | (20'(beats - int'(TC)) << 12);
                model_mem = beat_data(seed, beats);
                beats++;
            end else begin
                pend = 20'h0;
                bubbles++;
            end
            j++;
        end
        for (int k = 0; k < int'(COL + 2); k++)
            tw.push_back((k >= 1 && k <= int'(COL)) ? (LD | KRD | (20'(k - 1) << 12)) : LD);
        for (int k = 0; k < int'(GAP); k++) tw.push_back(20'h0);
        for (int r = 0; r < int'(TC); r++) tw.push_back(EXE | QRD | (20'(r) << 12));
        for (int k = 0; k < int'(GAP); k++) tw.push_back(20'h0);
        for (int r = 0; r < int'(TC); r++) tw.push_back(OFR | PWR | (20'(r) << 8));
        for (int r = 0; r < int'(TC); r++) tw.push_back(SACC | PRD | (20'(r) << 8));
        tw.push_back(SDIV);
        for (int r = 0; r < int'(TC); r++) begin
            tw.push_back(SDIV | PRD | (20'(r) << 8));
            tw.push_back(SWR | PWR | (20'(r) << 8));
        end
        tw.push_back(20'h0);
        foreach (tw[i]) push(tw[i] | ((i == 0) ? pend : 20'h0), 1'b1, i == tw.size() - 1, 1'b0);
        for (int k = 0; k < 4; k++) push(20'h0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("inst", W'(inst), W'(e.inst));
            chk("busy", W'(busy), W'(e.busy));
            chk("done", W'(done), W'(e.done));
            chk("in_ready", W'(in_ready), W'(e.rdy));
            chk("mem_in", mem_in, e.mem);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic run_pass(input logic [31:0] mask, input int seed, input logic valid_after,
                            input int abort_at, input int start_at, input logic pin);
        int cyc = 0, nbusy = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        build(mask, seed);
        if (pin) begin
            foreach (exp_q[i]) if (exp_q[i].busy) nbusy++;
            chk("pin_len", W'(nbusy), W'(88));
            chk("pin_q1", W'(exp_q[1].inst), W'(20'h00010));
            chk("pin_load0", W'(exp_q[16].inst), W'(20'h07044));
            chk("pin_load1", W'(exp_q[17].inst), W'(20'h00048));
            chk("pin_exec0", W'(exp_q[36].inst), W'(20'h000A0));
            chk("pin_drain2", W'(exp_q[56].inst), W'(20'h10201));
            chk("pin_wb0", W'(exp_q[71].inst), W'(20'h40002));
            chk("pin_wb1", W'(exp_q[72].inst), W'(20'h80001));
            chk("pin_wb14", W'(exp_q[85].inst), W'(20'h40702));
            chk("pin_done", W'(exp_q[87].done), W'(1'b1));
        end
        while (exp_q.size() > 0 && cyc < 400) begin
            reset = (cyc == abort_at);
            start = (cyc == start_at);
            if (cyc < sv_valid.size()) begin
                in_valid = sv_valid[cyc];
                in_data  = sv_data[cyc];
            end else begin
                in_valid = valid_after;
                in_data  = beat_data(seed, 99);
            end
            if (cyc == abort_at) begin
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                model_mem = '0;
                for (int k = 0; k < 3; k++) push(20'h0, 1'b0, 1'b0, 1'b0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("pending_cycles", W'(exp_q.size()), W'(0));
        exp_q.delete();
        if (abort_at < 0) begin
            chk("busy_len", W'(busy_cnt), W'(88 + bubbles));
            chk("done_pulses", W'(done_cnt), W'(1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        model_mem = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst", W'(inst), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_ready", W'(in_ready), W'(0));
        chk("rst_mem", mem_in, '0);
        reset = 1'b0;

        run_pass(32'h0, 1, 1'b1, -1, -1, 1'b1);           // valid held high past last beat
        run_pass(32'hA, 2, 1'b0, -1, -1, 1'b0);           // bubbles: valid 1,0,1,0,...
        run_pass(32'h0, 3, 1'b0, 38, -1, 1'b0);           // reset mid-EXEC
        run_pass(32'h0, 4, 1'b0, -1, 16 + 10 + 10 + 8 + 10 + 3, 1'b0); // start during DRAIN

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
